branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/sat_cnt2.sv | 22 ++
 rtl/branch_predictor.sv | 90 +++++++++
 tb/tb_branch_predictor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the branch history table and pipeline control classes.
package rv32i_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned BR_W  = 2;

  // 2-bit saturating counter states of a BHT entry
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Control class of an instruction; any code with bit 1 set is a jump
  localparam logic [BR_W-1:0] BR_NONE = 2'b00;
  localparam logic [BR_W-1:0] BR_COND = 2'b01;
  localparam logic [BR_W-1:0] BR_JUMP = 2'b10;

  // Every entry starts weakly not-taken
  localparam bht_state_e BHT_RESET = WNT;

endpackage

// File: rtl/sat_cnt2.sv
// Next value of a 2-bit saturating counter, nudged towards the resolved outcome.
module sat_cnt2
  import rv32i_pkg::*;
(
  input  bht_state_e cnt_i,
  input  logic       taken_i,
  output bht_state_e cnt_o
);

  // Step one state towards taken/not-taken, holding at ST/SNT
  always_comb begin
    cnt_o = cnt_i;
    case (cnt_i)
      SNT:     cnt_o = taken_i ? WNT : SNT;
      WNT:     cnt_o = taken_i ? WT  : SNT;
      WT:      cnt_o = taken_i ? ST  : WNT;
      ST:      cnt_o = taken_i ? ST  : WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit counters, read in ID,
// trained in EXE, plus resolved-branch and misprediction counters.
module branch_predictor
  import rv32i_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BR_W-1:0]  branch,
  input  logic [31:0]      ID_pc,
  input  logic [BR_W-1:0]  ID_EXE_branch,
  input  logic [31:0]      ID_EXE_pc,
  input  logic             ID_EXE_prediction,
  input  logic             branch_taken,
  output logic             prediction,
  output logic             misprediction,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned N_ENT = 1 << IDX_W;

  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] exe_idx;
  logic             upd;
  bht_state_e       bht_q [N_ENT];
  bht_state_e       rd_ent;
  bht_state_e       exe_ent;
  bht_state_e       exe_ent_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  // PC bits outside the word index do not take part in prediction
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ID_pc[31:IDX_W+2], ID_pc[1:0],
                            ID_EXE_pc[31:IDX_W+2], ID_EXE_pc[1:0]};

  assign id_idx  = ID_pc[IDX_W+1:2];
  assign exe_idx = ID_EXE_pc[IDX_W+1:2];
  assign upd     = (ID_EXE_branch == BR_COND);
  assign rd_ent  = bht_q[id_idx];
  assign exe_ent = bht_q[exe_idx];

  sat_cnt2 u_sat_cnt2 (
    .cnt_i   (exe_ent),
    .taken_i (branch_taken),
    .cnt_o   (exe_ent_d)
  );

  // Prediction reads the registered table, so an update in the same cycle is not seen
  always_comb begin
    prediction    = 1'b0;
    misprediction = 1'b0;
    if (branch == BR_COND) prediction = rd_ent[1];
    if (upd) misprediction = (branch_taken != ID_EXE_prediction);
  end

  // Statistics counters wrap naturally
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd)           br_count_d = br_count_q + CNT_W'(1);
    if (misprediction) mp_count_d = mp_count_q + CNT_W'(1);
  end

  // Table is a flop array so reset clears every entry; reset wins over training
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ENT); i++) bht_q[i] <= BHT_RESET;
    end else if (upd) begin
      bht_q[exe_idx] <= exe_ent_d;
    end
  end

  // Statistics counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table plus hand-written corner sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  branch;
  logic [31:0] ID_pc;
  logic [1:0]  ID_EXE_branch;
  logic [31:0] ID_EXE_pc;
  logic        ID_EXE_prediction;
  logic        branch_taken;
  logic        prediction;
  logic        misprediction;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch            (branch),
    .ID_pc             (ID_pc),
    .ID_EXE_branch     (ID_EXE_branch),
    .ID_EXE_pc         (ID_EXE_pc),
    .ID_EXE_prediction (ID_EXE_prediction),
    .branch_taken      (branch_taken),
    .prediction        (prediction),
    .misprediction     (misprediction),
    .br_count          (br_count),
    .mp_count          (mp_count)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  br;
    logic [31:0] idpc;
    logic [1:0]  xbr;
    logic [31:0] xpc;
    logic        xpred;
    logic        tk;
    logic        e_pred;
    logic        e_mp;
    logic [31:0] e_brc;
    logic [31:0] e_mpc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later
  task automatic drive(input logic r, input logic [1:0] br, input logic [31:0] idpc,
                       input logic [1:0] xbr, input logic [31:0] xpc,
                       input logic xpred, input logic tk);
    @(negedge clk);
    rst = r; branch = br; ID_pc = idpc; ID_EXE_branch = xbr;
    ID_EXE_pc = xpc; ID_EXE_prediction = xpred; branch_taken = tk;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; branch = '0; ID_pc = '0; ID_EXE_branch = '0;
    ID_EXE_pc = '0; ID_EXE_prediction = 1'b0; branch_taken = 1'b0;

    //              rst   br     idpc      xbr    xpc       xp    tk    pred  mp    brc     mpc
    vecs[0]  = '{1'b0, 2'b01, 32'h40, 2'b00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 2'b00, 32'h00, 2'b01, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 2'b01, 32'h40, 2'b01, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1};
    vecs[3]  = '{1'b0, 2'b01, 32'h40, 2'b00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'd1};
    vecs[4]  = '{1'b0, 2'b00, 32'h00, 2'b01, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'd1};
    vecs[5]  = '{1'b0, 2'b01, 32'h40, 2'b00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd2};
    vecs[6]  = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd2};
    vecs[7]  = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'd2};
    vecs[8]  = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd2};
    vecs[9]  = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 32'd2};
    vecs[10] = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd2};
    vecs[11] = '{1'b0, 2'b01, 32'h08, 2'b01, 32'h08, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 32'd2};
    vecs[12] = '{1'b0, 2'b01, 32'h08, 2'b00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3};
    vecs[13] = '{1'b0, 2'b10, 32'h40, 2'b10, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3};
    vecs[14] = '{1'b0, 2'b01, 32'h40, 2'b00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd3};
    vecs[15] = '{1'b0, 2'b01, 32'h40, 2'b11, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'd9, 32'd3};
    vecs[16] = '{1'b0, 2'b01, 32'h40, 2'b00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd3};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].idpc, vecs[i].xbr, vecs[i].xpc,
            vecs[i].xpred, vecs[i].tk);
      check($sformatf("v%0d.prediction", i),    32'(prediction),    32'(vecs[i].e_pred));
      check($sformatf("v%0d.misprediction", i), 32'(misprediction), 32'(vecs[i].e_mp));
      check($sformatf("v%0d.br_count", i),      br_count,           vecs[i].e_brc);
      check($sformatf("v%0d.mp_count", i),      mp_count,           vecs[i].e_mpc);
    end

    // Collision: same entry read and trained in one cycle, no bypass
    do_reset();
    drive(1'b0, 2'b01, 32'h100, 2'b01, 32'h100, 1'b0, 1'b1);
    check("coll.pred_same_cycle", 32'(prediction), 32'd0);
    check("coll.mispred", 32'(misprediction), 32'd1);
    drive(1'b0, 2'b01, 32'h100, 2'b00, 32'h0, 1'b0, 1'b0);
    check("coll.pred_next_cycle", 32'(prediction), 32'd1);
    check("coll.br_count", br_count, 32'd1);
    check("coll.mp_count", mp_count, 32'd1);

    // Aliasing: 0x00 and 0x40 share entry 0; then reset during an update
    do_reset();
    drive(1'b0, 2'b00, 32'h0, 2'b01, 32'h00, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 32'h0, 2'b01, 32'h00, 1'b1, 1'b1);
    drive(1'b0, 2'b01, 32'h40, 2'b00, 32'h0, 1'b0, 1'b0);
    check("alias.pred", 32'(prediction), 32'd1);
    check("alias.br_count", br_count, 32'd2);
    check("alias.mp_count", mp_count, 32'd1);
    drive(1'b1, 2'b00, 32'h0, 2'b01, 32'h00, 1'b0, 1'b1);
    drive(1'b0, 2'b01, 32'h40, 2'b00, 32'h0, 1'b0, 1'b0);
    check("rst.pred", 32'(prediction), 32'd0);
    check("rst.br_count", br_count, 32'd0);
    check("rst.mp_count", mp_count, 32'd0);
    // One taken from WNT must reach WT
    drive(1'b0, 2'b00, 32'h0, 2'b01, 32'h40, 1'b0, 1'b1);
    drive(1'b0, 2'b01, 32'h00, 2'b00, 32'h0, 1'b0, 1'b0);
    check("rst.entry_wnt", 32'(prediction), 32'd1);
    check("rst.br_count_after", br_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
